fm_pm_generator: RTL

FM_PM_GENERATOR -- requirements
Module: fm_pm_generator

---
 rtl/fm_pm_generator.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fm_pm_generator.sv
// FM/PM tone generator: a modulating sine tone drives the frequency or the
// phase of a carrier sine.
// The pipeline has four stages: modulating phase, modulating sample,
// scaled offset, carrier phase, then the output lookup.

// Sine lookup built from a quarter-wave table of 2^(PW-2)+1 entries.
// The table is filled from constant real expressions at elaboration time.
module fm_pm_sine_lut #(
  parameter int SW = 16,
  parameter int PW = 12
) (
  input  logic [PW-1:0] addr,
  output logic [SW-1:0] val
);
  localparam int  QN  = 1 << (PW - 2);
  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = (2.0 ** (SW - 1)) - 1.0;

  logic [SW-1:0] qtab [0:QN];

  for (genvar i = 0; i <= QN; i++) begin : g_tab
    assign qtab[i] = SW'($rtoi(AMP * $sin(2.0 * PI * real'(i) / real'(1 << PW)) + 0.5));
  end

  logic [PW-2:0] ridx;
  logic [SW-1:0] mag;

  // Mirror the index in odd quadrants and negate the value in the second half-wave.
  always_comb begin
    ridx = addr[PW-2] ? ((PW-1)'(QN) - {1'b0, addr[PW-3:0]}) : {1'b0, addr[PW-3:0]};
    mag  = qtab[ridx];
    val  = addr[PW-1] ? (~mag + 1'b1) : mag;
  end
endmodule

module fm_pm_generator #(
  parameter int SW = 16,
  parameter int PW = 12,
  parameter int AW = 32,
  parameter int DW = 5
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic          i_update,
  input  logic          i_sync,
  input  logic [1:0]    i_mode,
  input  logic [AW-1:0] i_carrier_inc,
  input  logic [AW-1:0] i_mod_inc,
  input  logic [DW-1:0] i_dev_shift,
  output logic [SW-1:0] o_sample,
  output logic          o_valid
);
  localparam logic [1:0] MODE_CW   = 2'd0;
  localparam logic [1:0] MODE_FM   = 2'd1;
  localparam logic [1:0] MODE_PM   = 2'd2;
  localparam logic [1:0] MODE_MUTE = 2'd3;
  localparam int STAGES = 4;

  // Wide enough to hold the largest shifted sample with no overflow and to
  // compare against the AW-bit saturation limits.
  localparam int XW = ((SW + (1 << DW)) > AW ? (SW + (1 << DW)) : AW) + 1;
  localparam logic signed [XW-1:0] SAT_HI = {{(XW-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_LO = -SAT_HI;

  // Active parameter registers
  logic [1:0]    mode;
  logic [AW-1:0] car_inc;
  logic [AW-1:0] mod_inc;
  logic [DW-1:0] dev_shift;

  // Pipeline state
  logic [AW-1:0]   ma;
  logic [SW-1:0]   m;
  logic [AW-1:0]   offset;
  logic [AW-1:0]   ca;
  logic [PW-1:0]   ph_addr;
  logic [1:0]      mode_ph;
  logic [STAGES:1] vld_pipe;

  // Combinational next values
  logic [SW-1:0]          m_lut;
  logic [SW-1:0]          s_lut;
  logic signed [XW-1:0]   m_x;
  logic signed [XW-1:0]   sh_x;
  logic [AW-1:0]          offset_nx;
  logic [AW-1:0]          ca_nx;
  logic [AW-1:0]          phase_nx;
  logic [SW-1:0]          sample_nx;
  logic                   unused_phase_lsb;

  fm_pm_sine_lut #(.SW(SW), .PW(PW)) u_mod_lut (
    .addr (ma[AW-1:AW-PW]),
    .val  (m_lut)
  );

  fm_pm_sine_lut #(.SW(SW), .PW(PW)) u_car_lut (
    .addr (ph_addr),
    .val  (s_lut)
  );

  // Scale the modulating sample and clamp it; a zero sample stays zero for any shift.
  always_comb begin
    m_x  = {{(XW-SW){m[SW-1]}}, m};
    sh_x = m_x <<< dev_shift;
    if (sh_x > SAT_HI)      offset_nx = SAT_HI[AW-1:0];
    else if (sh_x < SAT_LO) offset_nx = SAT_LO[AW-1:0];
    else                    offset_nx = sh_x[AW-1:0];
  end

  // The carrier accumulator takes the offset in FM; the phase takes it in PM.
  // MUTE and CW advance the carrier the same way.
  always_comb begin
    ca_nx     = ca + car_inc + ((mode == MODE_FM) ? offset : '0);
    phase_nx  = ca_nx + ((mode == MODE_PM) ? offset : '0);
    sample_nx = (mode_ph == MODE_MUTE) ? '0 : s_lut;
  end

  assign unused_phase_lsb = ^phase_nx[AW-PW-1:0];
  assign o_valid          = vld_pipe[STAGES];

  // Parameter capture happens whenever i_update is high, independent of i_ce.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mode      <= MODE_CW;
      car_inc   <= '0;
      mod_inc   <= '0;
      dev_shift <= '0;
    end else if (i_update) begin
      mode      <= i_mode;
      car_inc   <= i_carrier_inc;
      mod_inc   <= i_mod_inc;
      dev_shift <= i_dev_shift;
    end
  end

  // Pipeline steps on i_ce; sync clears it and restarts the valid count.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ma       <= '0;
      m        <= '0;
      offset   <= '0;
      ca       <= '0;
      ph_addr  <= '0;
      mode_ph  <= MODE_CW;
      o_sample <= '0;
      vld_pipe <= '0;
    end else if (i_sync) begin
      ma       <= '0;
      m        <= '0;
      offset   <= '0;
      ca       <= '0;
      ph_addr  <= '0;
      mode_ph  <= MODE_CW;
      o_sample <= '0;
      vld_pipe <= '0;
    end else if (i_ce) begin
      ma       <= ma + mod_inc;
      m        <= m_lut;
      offset   <= offset_nx;
      ca       <= ca_nx;
      ph_addr  <= phase_nx[AW-1:AW-PW];
      mode_ph  <= mode;
      o_sample <= sample_nx;
      vld_pipe <= {vld_pipe[STAGES-1:1], 1'b1};
    end
  end
endmodule
